gnss_iq_capture_packer: RTL and testbench

// - Captures quantised GNSS I/Q samples from the slow asynchronous adc_clk into clk.
// - Packs SAMPLE_BITS-wide samples (I-only or interleaved I/Q) LSB-first into WORD_WIDTH words.
// - Writes a programmable number of words into a block-RAM capture buffer, one single-cycle write per word.
// - Sits between the RF front-end pins and the acquisition engine's sample BSRAM; replaces the fixed 1-bit/8-bit capture logic.

---
 rtl/gnss_iq_capture_packer_if.sv | 24 ++
 rtl/gnss_iq_capture_packer.sv | 193 +++++++++++++++++++
 tb/tb_gnss_iq_capture_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gnss_iq_capture_packer_if.sv
// Capture-buffer write bus: one single-cycle write per packed word.
// The packer drives the bus (master); the block RAM or a monitor observes it (slave).
interface gnss_iq_capture_packer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_we;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    input mem_addr,
    input mem_wdata,
    input mem_we
  );

endinterface

// File: rtl/gnss_iq_capture_packer.sv
// GNSS I/Q capture packer.
// Brings quantised I/Q samples from the slow asynchronous adc_clk domain into clk,
// packs them LSB-first into WORD_WIDTH words and writes a programmable number of
// words into the sample buffer, one single-cycle write per word.
module gnss_iq_capture_packer #(
  parameter int SAMPLE_BITS = 1,
  parameter int IQ_MODE     = 1,
  parameter int WORD_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adc_clk,
  input  logic [SAMPLE_BITS-1:0] adc_i,
  input  logic [SAMPLE_BITS-1:0] adc_q,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH:0]    num_words,
  gnss_iq_capture_packer_if.master mem,
  output logic                   busy,
  output logic                   done
);

  // One lane is the bit group shifted in per ADC edge: {q,i} or just i.
  localparam int LANE_BITS = SAMPLE_BITS * ((IQ_MODE != 0) ? 2 : 1);
  localparam int SPW       = WORD_WIDTH / LANE_BITS;
  localparam int CNT_W     = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SPW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Synchroniser stages
  logic                   adc_clk_s1_q;
  logic                   adc_clk_s2_q;
  logic [SAMPLE_BITS-1:0] adc_i_s1_q;
  logic [SAMPLE_BITS-1:0] adc_i_s2_q;
  logic                   edge_flag;

  // Packing and control state
  state_t                 state_q;
  logic [ADDR_WIDTH:0]    num_q;
  logic [ADDR_WIDTH:0]    word_cnt_q;
  logic [CNT_W-1:0]       samp_cnt_q;
  logic [WORD_WIDTH-1:0]  sreg_q;
  logic [WORD_WIDTH-1:0]  sreg_d;
  logic [LANE_BITS-1:0]   lane;

  // Registered outputs
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [WORD_WIDTH-1:0]  mem_wdata_q;
  logic                   mem_we_q;
  logic                   busy_q;
  logic                   done_q;

  // Two-flop synchronisers for the ADC clock and I sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_clk_s1_q <= 1'b0;
      adc_clk_s2_q <= 1'b0;
      adc_i_s1_q   <= '0;
      adc_i_s2_q   <= '0;
    end else begin
      adc_clk_s1_q <= adc_clk;
      adc_clk_s2_q <= adc_clk_s1_q;
      adc_i_s1_q   <= adc_i;
      adc_i_s2_q   <= adc_i_s1_q;
    end
  end

  // A rising ADC edge shows up as one clk of stage1 high while stage2 is still low.
  // Data changes on the falling ADC edge, so stage1 data is settled in that cycle.
  assign edge_flag = adc_clk_s1_q & ~adc_clk_s2_q;

  if (IQ_MODE != 0) begin : g_iq
    logic [SAMPLE_BITS-1:0] adc_q_s1_q;
    logic [SAMPLE_BITS-1:0] adc_q_s2_q;
    logic                   unused_sync;

    // Two-flop synchroniser for the Q sample.
    always_ff @(posedge clk) begin
      if (rst) begin
        adc_q_s1_q <= '0;
        adc_q_s2_q <= '0;
      end else begin
        adc_q_s1_q <= adc_q;
        adc_q_s2_q <= adc_q_s1_q;
      end
    end

    assign lane        = {adc_q_s1_q, adc_i_s1_q};
    // Second data stages only complete the synchroniser chain; samples come from stage1.
    assign unused_sync = ^{adc_i_s2_q, adc_q_s2_q};
  end else begin : g_i_only
    logic unused_sync;

    assign lane        = adc_i_s1_q;
    assign unused_sync = ^{adc_q, adc_i_s2_q};
  end

  // New lane enters at the MSB end so the first sample of a word ends in the LSBs.
  if (SPW > 1) begin : g_shift
    assign sreg_d = {lane, sreg_q[WORD_WIDTH-1:LANE_BITS]};
  end else begin : g_single
    logic unused_sreg;

    assign sreg_d      = lane;
    assign unused_sreg = ^sreg_q;
  end

  // Capture FSM: arming, packing, word writes and completion, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      word_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      sreg_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort has priority over a coincident start
          if (start && !abort) begin
            num_q      <= num_words;
            word_cnt_q <= '0;
            samp_cnt_q <= '0;
            if (num_words == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARM;
              busy_q  <= 1'b1;
            end
          end
        end

        S_ARM, S_CAPTURE: begin
          if (abort) begin
            // Partial word is dropped; a write not yet registered never happens.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if ((state_q == S_CAPTURE) && (word_cnt_q == num_q)) begin
            // Reached the cycle after the final write.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (edge_flag) begin
            // In ARM the first flag after arming is sample 0 of word 0.
            state_q <= S_CAPTURE;
            sreg_q  <= sreg_d;
            if (samp_cnt_q == SAMP_LAST) begin
              samp_cnt_q  <= '0;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= sreg_d;
              mem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
              word_cnt_q  <= word_cnt_q + 1'b1;
            end else begin
              samp_cnt_q <= samp_cnt_q + 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_gnss_iq_capture_packer.sv
// Testbench for gnss_iq_capture_packer: default I/Q build plus a 2-bit I-only
// build with a small buffer. Expected words come from a sample-table model.
module tb_gnss_iq_capture_packer;

  logic        clk = 1'b0;
  logic        adc_clk = 1'b0;
  logic        rst;
  logic        a1_i, a1_q;
  logic [1:0]  a2_i, a2_q;
  logic        start1, abort1, start2, abort2;
  logic [14:0] nw1;
  logic [3:0]  nw2;
  logic        busy1, done1, busy2, done2;

  gnss_iq_capture_packer_if #(.ADDR_WIDTH(14), .WORD_WIDTH(8)) m1 ();
  gnss_iq_capture_packer_if #(.ADDR_WIDTH(3),  .WORD_WIDTH(8)) m2 ();

  gnss_iq_capture_packer dut1 (
    .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_i(a1_i), .adc_q(a1_q),
    .start(start1), .abort(abort1), .num_words(nw1), .mem(m1),
    .busy(busy1), .done(done1)
  );

  gnss_iq_capture_packer #(.SAMPLE_BITS(2), .IQ_MODE(0), .WORD_WIDTH(8), .ADDR_WIDTH(3)) dut2 (
    .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_i(a2_i), .adc_q(a2_q),
    .start(start2), .abort(abort2), .num_words(nw2), .mem(m2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always #43 adc_clk = ~adc_clk;

  // Sample tables: s1_tab holds {q,i} for dut1, s2_tab holds the 2-bit I for dut2.
  logic [1:0] s1_tab [0:63];
  logic [1:0] s2_tab [0:63];
  int adc_idx  = 0;
  int adc_base = 0;

  always @(negedge adc_clk) begin
    int rel;
    rel  = (adc_idx - adc_base) & 63;
    a1_i = s1_tab[rel][0];
    a1_q = s1_tab[rel][1];
    a2_i = s2_tab[rel];
    a2_q = 2'($urandom);
    adc_idx++;
  end

  // Bus monitors, sampled 1 ns after the active edge.
  int          cyc = 0;
  int          wa1[$], wa2[$];
  logic [7:0]  wd1[$], wd2[$];
  int          dn1 = 0, dn2 = 0, dn1_cyc = 0, dn2_cyc = 0;
  int          dn1_pwe = 0, dn2_pwe = 0, cw1 = 0, cw2 = 0;
  logic        prev1 = 1'b0, prev2 = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (m1.mem_we === 1'b1) begin
      wa1.push_back(int'(m1.mem_addr));
      wd1.push_back(m1.mem_wdata);
      if (prev1) cw1++;
    end
    if (done1 === 1'b1) begin dn1++; dn1_cyc = cyc; dn1_pwe = int'(prev1); end
    prev1 = (m1.mem_we === 1'b1);
    if (m2.mem_we === 1'b1) begin
      wa2.push_back(int'(m2.mem_addr));
      wd2.push_back(m2.mem_wdata);
      if (prev2) cw2++;
    end
    if (done2 === 1'b1) begin dn2++; dn2_cyc = cyc; dn2_pwe = int'(prev2); end
    prev2 = (m2.mem_we === 1'b1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word j = samples 4j..4j+3 after the start, sample s in bits [2s+1:2s].
  function automatic logic [7:0] model(input int which, input int j);
    logic [7:0] w;
    w = '0;
    for (int s = 0; s < 4; s++)
      w[2*s +: 2] = (which == 1) ? s1_tab[(4*j + s) % 64] : s2_tab[(4*j + s) % 64];
    return w;
  endfunction

  task automatic check_writes(input int which, input int wb, input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      int a;
      logic [7:0] d;
      if (which == 1) begin a = wa1[wb + j]; d = wd1[wb + j]; end
      else            begin a = wa2[wb + j]; d = wd2[wb + j]; end
      chk({tag, "_addr"}, a, j);
      chk({tag, "_data"}, d, model(which, j));
    end
  endtask

  // Rewind the sample tables so the next ADC rising edge carries sample 0, then start.
  task automatic launch(input int which, input int nw, output int tstart);
    @(posedge adc_clk);
    adc_base = adc_idx;
    @(negedge adc_clk);
    @(negedge clk);
    if (which == 1) begin nw1 = 15'(nw); start1 = 1'b1; end
    else            begin nw2 = 4'(nw);  start2 = 1'b1; end
    tstart = cyc;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int d0, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (((which == 1) ? dn1 : dn2) > d0) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_writes(input int which, input int target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (((which == 1) ? wa1.size() : wa2.size()) >= target) begin seen = 1'b1; break; end
    end
    chk({tag, "_write_seen"}, seen, 1);
  endtask

  typedef struct {
    int         nw;
    int         pat;        // 0: i=1,q=0  1: (q,i) counter  2: random
    int         exp_writes;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vt [5];

  initial begin
    int ts, wb, d0, n, dl;
    vt[0] = '{nw: 1, pat: 0, exp_writes: 1, exp_word: 8'h55};
    vt[1] = '{nw: 3, pat: 1, exp_writes: 3, exp_word: 8'hE4};
    vt[2] = '{nw: 0, pat: 0, exp_writes: 0, exp_word: 8'h00};
    vt[3] = '{nw: 5, pat: 2, exp_writes: 5, exp_word: 8'h00};
    vt[4] = '{nw: 9, pat: 2, exp_writes: 9, exp_word: 8'h00};

    for (int k = 0; k < 64; k++) begin s1_tab[k] = 2'd0; s2_tab[k] = 2'(k % 4); end
    rst = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    nw1 = '0; nw2 = '0;
    repeat (5) @(negedge clk);
    chk("reset_dut1", {m1.mem_addr, m1.mem_wdata, m1.mem_we, busy1, done1}, 0);
    chk("reset_dut2", {m2.mem_addr, m2.mem_wdata, m2.mem_we, busy2, done2}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Table-driven captures on the default I/Q build.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 64; k++)
        s1_tab[k] = (vt[v].pat == 0) ? 2'b01 : (vt[v].pat == 1) ? 2'(k % 4) : 2'($urandom);
      wb = wa1.size();
      d0 = dn1;
      launch(1, vt[v].nw, ts);
      wait_done(1, d0, 60 * vt[v].nw + 100, $sformatf("vec%0d", v));
      n = wa1.size() - wb;
      chk($sformatf("vec%0d_writes", v), n, vt[v].exp_writes);
      chk($sformatf("vec%0d_done_cnt", v), dn1 - d0, 1);
      if (n > vt[v].exp_writes) n = vt[v].exp_writes;
      check_writes(1, wb, n, $sformatf("vec%0d", v));
      for (int j = 0; j < n; j++)
        if (vt[v].pat != 2) chk($sformatf("vec%0d_word_tab", v), wd1[wb + j], vt[v].exp_word);
      if (vt[v].nw > 0) begin
        chk($sformatf("vec%0d_done_after_we", v), dn1_pwe, 1);
      end else begin
        dl = dn1_cyc - ts;
        chk("zero_done_latency", (dl >= 1 && dl <= 2), 1);
      end
      chk($sformatf("vec%0d_busy_low", v), busy1, 0);
    end

    // Abort after two samples of word 1, then restart with fresh packing.
    for (int k = 0; k < 64; k++) s1_tab[k] = 2'(k % 4);
    wb = wa1.size();
    d0 = dn1;
    launch(1, 4, ts);
    wait_writes(1, wb + 1, "abort");
    repeat (2) @(posedge adc_clk);
    repeat (4) @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort_busy_next", busy1, 0);
    repeat (150) @(negedge clk);
    chk("abort_writes", wa1.size() - wb, 1);
    chk("abort_no_done", dn1 - d0, 0);
    if (wa1.size() > wb) check_writes(1, wb, 1, "abort");
    wb = wa1.size();
    d0 = dn1;
    launch(1, 2, ts);
    wait_done(1, d0, 250, "restart");
    chk("restart_writes", wa1.size() - wb, 2);
    if (wa1.size() - wb >= 2) begin
      check_writes(1, wb, 2, "restart");
      chk("restart_word1", wd1[wb + 1], 8'hE4);
    end

    // Reset in the middle of a word.
    wb = wa1.size();
    launch(1, 4, ts);
    wait_writes(1, wb + 1, "rstmid");
    repeat (2) @(posedge adc_clk);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_outputs", {m1.mem_addr, m1.mem_wdata, m1.mem_we, busy1, done1}, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("rstmid_no_more_we", wa1.size() - wb, 1);

    // Simultaneous start and abort in IDLE.
    wb = wa1.size();
    d0 = dn1;
    @(negedge clk);
    nw1 = 15'd2; start1 = 1'b1; abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; abort1 = 1'b0;
    chk("start_abort_busy", busy1, 0);
    repeat (150) @(negedge clk);
    chk("start_abort_writes", wa1.size() - wb, 0);
    chk("start_abort_done", dn1 - d0, 0);
    chk("dut1_no_back_to_back_we", cw1, 0);

    // I-only 2-bit build: ramp, with an extra start pulse while busy.
    for (int k = 0; k < 64; k++) s2_tab[k] = 2'(k % 4);
    wb = wa2.size();
    d0 = dn2;
    launch(2, 3, ts);
    wait_writes(2, wb + 1, "ionly");
    @(negedge clk);
    nw2 = 4'd7; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(2, d0, 300, "ionly");
    repeat (100) @(negedge clk);
    chk("ionly_writes", wa2.size() - wb, 3);
    chk("ionly_done_cnt", dn2 - d0, 1);
    if (wa2.size() - wb >= 3) begin
      check_writes(2, wb, 3, "ionly");
      chk("ionly_word_E4", wd2[wb + 2], 8'hE4);
    end

    // Full buffer on the 3-bit address build with random samples.
    for (int k = 0; k < 64; k++) s2_tab[k] = 2'($urandom);
    wb = wa2.size();
    d0 = dn2;
    launch(2, 8, ts);
    wait_done(2, d0, 700, "full");
    repeat (100) @(negedge clk);
    chk("full_writes", wa2.size() - wb, 8);
    chk("full_done_cnt", dn2 - d0, 1);
    chk("full_done_after_we", dn2_pwe, 1);
    if (wa2.size() - wb >= 8) begin
      check_writes(2, wb, 8, "full");
      chk("full_last_addr", wa2[wb + 7], 7);
    end
    chk("full_addr_hold", m2.mem_addr, 3'd7);
    chk("dut2_no_back_to_back_we", cw2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
